// File: rtl/bus_responder_pkg.sv
// Shared bus package: chip-select type, device index constants and the
// responder FSM state encoding, also used by the address decoder.
package bus_responder_pkg;

  localparam int NUM_DEVICES = 14;
  localparam int CS_IDX_W    = 4;

  // One-hot chip selects, one bit per device.
  typedef logic [NUM_DEVICES-1:0] SChipCS;

  // Bit positions of each device inside SChipCS.
  localparam int CS_ROM   = 0;
  localparam int CS_UART  = 1;
  localparam int CS_TIMER = 2;
  localparam int CS_SPI   = 3;
  localparam int CS_GPU   = 4;
  localparam int CS_APU   = 5;
  localparam int CS_DMA   = 6;
  localparam int CS_IRQ   = 7;
  localparam int CS_I2C   = 8;
  localparam int CS_PAD   = 9;
  localparam int CS_SD    = 10;
  localparam int CS_VRAM  = 11;
  localparam int CS_RAM   = 12;
  localparam int CS_EXT   = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } bus_state_t;

  // Expand a device index back into its single chip-select bit.
  function automatic SChipCS cs_from_idx(input logic [CS_IDX_W-1:0] idx);
    return SChipCS'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Bus responder interface: CPU request side, decoder flags and the
// per-device request/ack/data lanes. The responder is the slave side.
interface bus_responder_if import bus_responder_pkg::*; ();

  logic                             i_req;
  logic                             i_write;
  logic [31:0]                      i_wdata;
  logic [3:0]                       i_byteEn;
  SChipCS                           i_csPins;
  logic                             i_busError;
  SChipCS                           o_devReq;
  logic                             o_devWrite;
  logic [31:0]                      o_devWData;
  logic [3:0]                       o_devByteEn;
  SChipCS                           i_devAck;
  logic [NUM_DEVICES-1:0][31:0]     i_devRData;
  logic                             o_ack;
  logic [31:0]                      o_rdata;
  logic                             o_busError;
  logic                             o_busy;

  modport slave (
    input  i_req, i_write, i_wdata, i_byteEn, i_csPins, i_busError,
    input  i_devAck, i_devRData,
    output o_devReq, o_devWrite, o_devWData, o_devByteEn,
    output o_ack, o_rdata, o_busError, o_busy
  );

  modport master (
    output i_req, i_write, i_wdata, i_byteEn, i_csPins, i_busError,
    output i_devAck, i_devRData,
    input  o_devReq, o_devWrite, o_devWData, o_devByteEn,
    input  o_ack, o_rdata, o_busError, o_busy
  );

endinterface

// File: rtl/bus_responder_onehot_enc.sv
// One-hot to index encoder for the chip-select vector. Reports the lowest
// set bit as the index and flags whether exactly one bit was set.
module bus_onehot_enc import bus_responder_pkg::*; (
  input  SChipCS              onehot,
  output logic [CS_IDX_W-1:0] idx,
  output logic                is_onehot
);

  logic [CS_IDX_W-1:0] count;

  // Count set bits and remember the lowest one (scan runs high to low).
  always_comb begin
    idx   = '0;
    count = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        idx   = CS_IDX_W'(i);
        count = count + CS_IDX_W'(1);
      end
    end
    is_onehot = (count == CS_IDX_W'(1));
  end

endmodule

// File: rtl/bus_responder.sv
// Bus responder: accepts one CPU access at a time, strobes the selected
// device, waits for its ack with a timeout and returns a single ack pulse
// carrying read data or a bus-error flag back to the CPU.
module bus_responder import bus_responder_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            i_clk,
  input logic            i_rst,
  bus_responder_if.slave bus
);

  bus_state_t          state;
  logic [CS_IDX_W-1:0] cs_idx;
  logic [CS_IDX_W-1:0] dec_idx;
  logic                dec_onehot;
  logic [7:0]          wait_cnt;
  logic                idx_ack;
  logic [31:0]         idx_rdata;

  SChipCS              dev_req;
  logic                dev_write;
  logic [31:0]         dev_wdata;
  logic [3:0]          dev_byte_en;
  logic                ack;
  logic [31:0]         rdata;
  logic                bus_err;
  logic                busy;

  bus_onehot_enc u_enc (
    .onehot    (bus.i_csPins),
    .idx       (dec_idx),
    .is_onehot (dec_onehot)
  );

  // Only the ack and data lane of the latched device matter.
  assign idx_ack   = bus.i_devAck[cs_idx];
  assign idx_rdata = bus.i_devRData[cs_idx];

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cs_idx      <= '0;
      wait_cnt    <= '0;
      dev_req     <= '0;
      dev_write   <= 1'b0;
      dev_wdata   <= '0;
      dev_byte_en <= '0;
      ack         <= 1'b0;
      rdata       <= '0;
      bus_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dev_req <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_req) begin
            busy <= 1'b1;
            if (!bus.i_busError && dec_onehot) begin
              cs_idx      <= dec_idx;
              dev_write   <= bus.i_write;
              dev_wdata   <= bus.i_wdata;
              dev_byte_en <= bus.i_byteEn;
              dev_req     <= cs_from_idx(dec_idx);
              wait_cnt    <= '0;
              state       <= ST_ISSUE;
            end else begin
              ack     <= 1'b1;
              bus_err <= 1'b1;
              state   <= ST_ERR;
            end
          end
        end
        ST_ISSUE: begin
          if (idx_ack) begin
            ack   <= 1'b1;
            rdata <= dev_write ? 32'h0 : idx_rdata;
            state <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (idx_ack) begin
            ack   <= 1'b1;
            rdata <= dev_write ? 32'h0 : idx_rdata;
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
              ack     <= 1'b1;
              bus_err <= 1'b1;
              state   <= ST_ERR;
            end
          end
        end
        ST_RESP, ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_devReq    = dev_req;
  assign bus.o_devWrite  = dev_write;
  assign bus.o_devWData  = dev_wdata;
  assign bus.o_devByteEn = dev_byte_en;
  assign bus.o_ack       = ack;
  assign bus.o_rdata     = rdata;
  assign bus.o_busError  = bus_err;
  assign bus.o_busy      = busy;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder. Two instances share one stimulus:
// dut_a uses the default timeout, dut_b uses TIMEOUT_CYCLES=4.
module tb_bus_responder;
  import bus_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst;
  logic                         req;
  logic                         write;
  logic [31:0]                  wdata;
  logic [3:0]                   byte_en;
  SChipCS                       cs_pins;
  logic                         bus_error;
  SChipCS                       dev_ack;
  logic [NUM_DEVICES-1:0][31:0] dev_rdata;

  int checks   = 0;
  int failures = 0;

  bus_responder_if ifa ();
  bus_responder_if ifb ();

  assign ifa.i_req      = req;
  assign ifa.i_write    = write;
  assign ifa.i_wdata    = wdata;
  assign ifa.i_byteEn   = byte_en;
  assign ifa.i_csPins   = cs_pins;
  assign ifa.i_busError = bus_error;
  assign ifa.i_devAck   = dev_ack;
  assign ifa.i_devRData = dev_rdata;

  assign ifb.i_req      = req;
  assign ifb.i_write    = write;
  assign ifb.i_wdata    = wdata;
  assign ifb.i_byteEn   = byte_en;
  assign ifb.i_csPins   = cs_pins;
  assign ifb.i_busError = bus_error;
  assign ifb.i_devAck   = dev_ack;
  assign ifb.i_devRData = dev_rdata;

  bus_responder dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  bus_responder #(.TIMEOUT_CYCLES(4)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkOutputBit(input string tag, input logic observed,
                                input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input SChipCS cs,
                               input logic berr, input logic [31:0] wd,
                               input logic [3:0] be);
    req       = r;
    write     = w;
    cs_pins   = cs;
    bus_error = berr;
    wdata     = wd;
    byte_en   = be;
  endtask

  // Everything dut_a drives must be zero after reset.
  task automatic checkOutputAllZero(input string tag);
    $display("[TB] zero check: %s", tag);
    checkOutput("zero_devReq", 32'(ifa.o_devReq), 32'h0);
    checkOutputBit("zero_devWrite", ifa.o_devWrite, 1'b0);
    checkOutput("zero_devWData", ifa.o_devWData, 32'h0);
    checkOutput("zero_devByteEn", 32'(ifa.o_devByteEn), 32'h0);
    checkOutputBit("zero_ack", ifa.o_ack, 1'b0);
    checkOutput("zero_rdata", ifa.o_rdata, 32'h0);
    checkOutputBit("zero_busError", ifa.o_busError, 1'b0);
    checkOutputBit("zero_busy", ifa.o_busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
    dev_ack   = '0;
    dev_rdata = '0;
    tick();
    tick();
    checkOutputAllZero("after reset");
    rst = 1'b0;
    tick();

    // Read from RAM, ack during ISSUE.
    $display("[TB] read RAM, immediate ack");
    dev_rdata[CS_RAM] = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b0, SChipCS'(1) << CS_RAM, 1'b0, 32'h0, 4'hF);
    tick();
    checkOutput("rd_issue_devReq", 32'(ifa.o_devReq), 32'h0000_1000);
    checkOutputBit("rd_issue_ack", ifa.o_ack, 1'b0);
    checkOutputBit("rd_issue_busy", ifa.o_busy, 1'b1);
    req = 1'b0;
    dev_ack[CS_RAM] = 1'b1;
    tick();
    checkOutputBit("rd_resp_ack", ifa.o_ack, 1'b1);
    checkOutput("rd_resp_rdata", ifa.o_rdata, 32'hDEADBEEF);
    checkOutputBit("rd_resp_busError", ifa.o_busError, 1'b0);
    checkOutput("rd_resp_devReq", 32'(ifa.o_devReq), 32'h0);
    dev_ack = '0;
    tick();
    checkOutputBit("rd_idle_ack", ifa.o_ack, 1'b0);
    checkOutputBit("rd_idle_busy", ifa.o_busy, 1'b0);

    // Write to GPU, ack five cycles after ISSUE; latched fields must hold.
    $display("[TB] write GPU, delayed ack");
    dev_rdata[CS_GPU] = 32'hA5A5A5A5;
    applyStimulus(1'b1, 1'b1, SChipCS'(1) << CS_GPU, 1'b0, 32'h12345678, 4'h5);
    tick();
    checkOutput("wr_issue_devReq", 32'(ifa.o_devReq), 32'h0000_0010);
    checkOutputBit("wr_issue_devWrite", ifa.o_devWrite, 1'b1);
    checkOutput("wr_issue_devWData", ifa.o_devWData, 32'h12345678);
    checkOutput("wr_issue_devByteEn", 32'(ifa.o_devByteEn), 32'h5);
    applyStimulus(1'b0, 1'b0, SChipCS'(1) << CS_GPU, 1'b0, 32'hFFFFFFFF, 4'hF);
    for (int i = 2; i <= 6; i++) begin
      tick();
      checkOutput("wr_wait_devReq", 32'(ifa.o_devReq), 32'h0);
      checkOutput("wr_wait_devWData", ifa.o_devWData, 32'h12345678);
      checkOutput("wr_wait_devByteEn", 32'(ifa.o_devByteEn), 32'h5);
      checkOutputBit("wr_wait_ack", ifa.o_ack, 1'b0);
    end
    dev_ack[CS_GPU] = 1'b1;
    tick();
    checkOutputBit("wr_resp_ack", ifa.o_ack, 1'b1);
    checkOutput("wr_resp_rdata", ifa.o_rdata, 32'h0);
    checkOutputBit("wr_resp_busError", ifa.o_busError, 1'b0);
    checkOutputBit("wr_resp_devWrite", ifa.o_devWrite, 1'b1);
    checkOutput("wr_resp_devWData", ifa.o_devWData, 32'h12345678);
    dev_ack = '0;
    tick();
    checkOutputBit("wr_idle_busy", ifa.o_busy, 1'b0);

    // Decoder error flag.
    $display("[TB] decoder error flag");
    applyStimulus(1'b1, 1'b0, SChipCS'(1) << CS_RAM, 1'b1, 32'h0, 4'hF);
    tick();
    checkOutputBit("derr_ack", ifa.o_ack, 1'b1);
    checkOutputBit("derr_busError", ifa.o_busError, 1'b1);
    checkOutput("derr_devReq", 32'(ifa.o_devReq), 32'h0);
    checkOutput("derr_rdata", ifa.o_rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
    tick();
    checkOutputBit("derr_idle_ack", ifa.o_ack, 1'b0);
    checkOutputBit("derr_idle_busy", ifa.o_busy, 1'b0);

    // Two chip selects at once, then a request right after the error ack.
    $display("[TB] multi-hot chip select, back-to-back request");
    applyStimulus(1'b1, 1'b0, 14'h0011, 1'b0, 32'h0, 4'hF);
    tick();
    checkOutputBit("mhot_ack", ifa.o_ack, 1'b1);
    checkOutputBit("mhot_busError", ifa.o_busError, 1'b1);
    checkOutput("mhot_devReq", 32'(ifa.o_devReq), 32'h0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
    tick();
    checkOutputBit("mhot_idle_ack", ifa.o_ack, 1'b0);
    dev_rdata[CS_ROM] = 32'h0BADF00D;
    applyStimulus(1'b1, 1'b0, SChipCS'(1) << CS_ROM, 1'b0, 32'h0, 4'hF);
    tick();
    checkOutput("b2b_issue_devReq", 32'(ifa.o_devReq), 32'h0000_0001);
    req = 1'b0;
    dev_ack[CS_ROM] = 1'b1;
    tick();
    checkOutputBit("b2b_resp_ack", ifa.o_ack, 1'b1);
    checkOutput("b2b_resp_rdata", ifa.o_rdata, 32'h0BADF00D);
    dev_ack = '0;
    tick();

    // Timeout on dut_b: four WAIT cycles, then ERR; stray ack afterwards.
    $display("[TB] timeout without ack");
    dev_rdata[CS_TIMER] = 32'h11111111;
    applyStimulus(1'b1, 1'b0, SChipCS'(1) << CS_TIMER, 1'b0, 32'h0, 4'hF);
    tick();
    checkOutput("to_issue_devReq", 32'(ifb.o_devReq), 32'h0000_0004);
    req = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      checkOutputBit("to_wait_ack", ifb.o_ack, 1'b0);
      checkOutputBit("to_wait_busy", ifb.o_busy, 1'b1);
    end
    tick();
    checkOutputBit("to_err_ack", ifb.o_ack, 1'b1);
    checkOutputBit("to_err_busError", ifb.o_busError, 1'b1);
    checkOutput("to_err_rdata", ifb.o_rdata, 32'h0);
    dev_ack[CS_TIMER] = 1'b1;
    tick();
    checkOutputBit("to_stray_ack", ifb.o_ack, 1'b0);
    checkOutputBit("to_stray_busy", ifb.o_busy, 1'b0);
    tick();
    checkOutputBit("to_stray_ack2", ifb.o_ack, 1'b0);
    checkOutputBit("to_stray_busy2", ifb.o_busy, 1'b0);
    dev_ack = '0;
    tick();

    // Ack in the timeout cycle wins; a wrong-device ack does nothing.
    $display("[TB] ack on timeout cycle");
    dev_rdata[CS_EXT] = 32'hCAFEF00D;
    dev_rdata[CS_APU] = 32'h77777777;
    applyStimulus(1'b1, 1'b0, SChipCS'(1) << CS_EXT, 1'b0, 32'h0, 4'hF);
    tick();
    checkOutput("race_issue_devReq", 32'(ifb.o_devReq), 32'h0000_2000);
    req = 1'b0;
    tick();
    checkOutputBit("race_wait_busy", ifb.o_busy, 1'b1);
    tick();
    dev_ack[CS_APU] = 1'b1;
    tick();
    checkOutputBit("race_wrongdev_ack_b", ifb.o_ack, 1'b0);
    checkOutputBit("race_wrongdev_busy_b", ifb.o_busy, 1'b1);
    checkOutputBit("race_wrongdev_ack_a", ifa.o_ack, 1'b0);
    dev_ack = '0;
    tick();
    checkOutputBit("race_last_wait_ack", ifb.o_ack, 1'b0);
    dev_ack[CS_EXT] = 1'b1;
    tick();
    checkOutputBit("race_resp_ack", ifb.o_ack, 1'b1);
    checkOutputBit("race_resp_busError", ifb.o_busError, 1'b0);
    checkOutput("race_resp_rdata", ifb.o_rdata, 32'hCAFEF00D);
    checkOutput("race_resp_rdata_a", ifa.o_rdata, 32'hCAFEF00D);
    dev_ack = '0;
    tick();

    // Reset during WAIT aborts the access; a late ack is ignored.
    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b1, SChipCS'(1) << CS_I2C, 1'b0, 32'h55AA55AA, 4'hC);
    tick();
    checkOutput("rst_issue_devReq", 32'(ifa.o_devReq), 32'h0000_0100);
    req = 1'b0;
    tick();
    checkOutputBit("rst_wait_busy", ifa.o_busy, 1'b1);
    rst = 1'b1;
    tick();
    checkOutputAllZero("reset mid-transaction");
    rst = 1'b0;
    dev_ack[CS_I2C] = 1'b1;
    tick();
    checkOutputBit("rst_late_ack", ifa.o_ack, 1'b0);
    checkOutputBit("rst_late_busy", ifa.o_busy, 1'b0);
    dev_ack = '0;
    dev_rdata[CS_RAM] = 32'h600DCAFE;
    applyStimulus(1'b1, 1'b0, SChipCS'(1) << CS_RAM, 1'b0, 32'h0, 4'hF);
    tick();
    checkOutput("post_rst_devReq", 32'(ifa.o_devReq), 32'h0000_1000);
    req = 1'b0;
    dev_ack[CS_RAM] = 1'b1;
    tick();
    checkOutputBit("post_rst_ack", ifa.o_ack, 1'b1);
    checkOutput("post_rst_rdata", ifa.o_rdata, 32'h600DCAFE);
    dev_ack = '0;
    tick();
    checkOutputBit("post_rst_idle_busy", ifa.o_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
